harris_run_ctrl: RTL and testbench
==================================

// Module: harris_run_ctrl
// PURPOSE
//  Sequences one run of a Harris kernel (HIR or HLS build) against its 1024x32 output memory.
//  On cmd_start it pulses the kernel start and snoops the kernel's output-memory write port.
//  It counts N_OUT writes (or times out), then reads the output memory back as a valid/ready stream.
//  Sits between the test/host control logic and the kernel/memref_rd/memref_wr instances.
// PARAMETERS
//  ADDR_W   10     output memory address width
//  DATA_W   32     output memory data width
//  N_OUT    1024   writes expected per run = beats streamed back; 1..2**ADDR_W
//  TIMEOUT  65535  max cycles in RUN before abort; >= 1
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  rst            in   1       asynchronous, active-high reset
//  cmd_start      in   1       run request; sampled only in IDLE
//  busy           out  1       high in every state except IDLE
//  done           out  1       1-cycle pulse at end of run (success or error)
//  err_timeout    out  1       sticky; set on timeout, cleared by next accepted cmd_start
//  err_order      out  1       sticky write-order error (only with HARRIS_RUN_CTRL_WRCHK_EN)
//  kernel_t       out  1       kernel start pulse (drives .t of the kernel)
//  kernel_wr_en   in   1       snooped kernel output write enable
//  kernel_wr_addr in   ADDR_W  snooped kernel output write address
//  out_rd_en      out  1       readback read enable to memref_rd
//  out_rd_addr    out  ADDR_W  readback address
//  out_rd_data    in   DATA_W  read data, valid exactly 1 cycle after out_rd_en
//  m_valid        out  1       stream beat valid
//  m_ready        in   1       stream beat accept
//  m_data         out  DATA_W  stream data
//  m_last         out  1       marks beat for address N_OUT-1
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; counters 0; skid buffer empty.
//  FSM states: IDLE -> START -> RUN -> READ -> FIN -> IDLE; RUN -> FIN on timeout.
//   IDLE:  cmd_start=1 -> START; clear err_timeout and err_order.
//   START: kernel_t=1 for exactly this one cycle (cycle after cmd_start); -> RUN.
//   RUN:   wr_cnt increments on each kernel_wr_en.
//     - wr_cnt reaches N_OUT -> READ.
//     - run-cycle counter reaches TIMEOUT first -> set err_timeout, -> FIN (readback skipped).
//     - if the N_OUT-th write and timeout land on the same cycle, completion wins.
//   READ:  issue out_rd_en with addresses 0..N_OUT-1 in order.
//     - issue only while (buffered + in-flight) < 2.
//     - returned data enters a 2-entry skid buffer that drives m_valid/m_data/m_last.
//     - first m_valid no earlier than 2 cycles after entering READ.
//     - m_data holds stable while m_valid & !m_ready.
//     - full throughput (1 beat/cycle) when m_ready is held high.
//     - accepted beat with m_last -> FIN.
//   FIN:   done=1 for one cycle; -> IDLE.
//  cmd_start is ignored when busy=1; it is not queued.
//  kernel_wr_en outside RUN is ignored (not counted).
//  Counters are wide enough for N_OUT and TIMEOUT (clog2(+1)); no wrap within a run.
//  rst asserted mid-run aborts immediately to IDLE; no done pulse; in-flight read data is discarded.
// CONFIGURATION
//  HARRIS_RUN_CTRL_WRCHK_EN defined:
//    - in RUN, each kernel write must have kernel_wr_addr == wr_cnt (dense, ascending).
//    - a mismatch sets err_order (sticky); counting continues.
//  HARRIS_RUN_CTRL_WRCHK_EN undefined: no checker logic; err_order tied 0.
// STRUCTURE
//  Package harris_ctrl_pkg:
//    - state enum (IDLE, START, RUN, READ, FIN)
//    - clog2-based width helper
//    - default ADDR_W and DATA_W constants
//  Sub-module harris_skid_buf: 2-entry valid/ready buffer, DATA_W+1 bits wide (data + last).
//  The top-level block holds the FSM, counters, read-issue credit logic and the optional checker.
// TESTING
//  1. Reset, then cmd_start at cycle 0.
//     -> kernel_t=1 at cycle 1 only; busy=1 from cycle 1.
//  2. Model writes 0..1023 sequentially, m_ready=1.
//     -> 1024 beats, data equals memory, m_last on beat 1023, done pulses once, busy=0 next cycle.
//  3. Same run, m_ready toggling 1/0 each cycle and random stalls.
//     -> no lost or duplicated beats; m_data stable while stalled.
//  4. TIMEOUT=100, model writes only 10 words.
//     -> err_timeout=1 and done at RUN cycle 100; no m_valid; next cmd_start clears err_timeout.
//  5. cmd_start pulses during RUN and READ -> ignored, single run only.
//     Async rst mid-READ -> all outputs 0 immediately.
//  6. WRCHK_EN build, write addr 5 issued twice (at wr_cnt 5 and 6) -> err_order=1;
//     non-WRCHK build -> err_order stays 0.

Source files
------------

// File: rtl/harris_ctrl_pkg.sv
// Shared types and constants for the Harris run controller.
// Holds the FSM state enum, a counter-width helper and the default memory geometry.
package harris_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_READ  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/harris_skid_buf.sv
// 2-entry valid/ready buffer; data written in appears on out_dat one cycle later.
// Latency 1 cycle; an entry is held stable on out_dat while out_vld & !out_rdy.
// Writer must respect cnt (credit view); a push into a full buffer without a pop is dropped.
module harris_skid_buf #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [1:0]   cnt
);

  logic [W-1:0] ent_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         pop;
  logic         push;

  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = ent_q[rd_ptr_q];
  assign cnt     = cnt_q;
  assign pop     = out_vld & out_rdy;
  assign push    = in_vld & ((cnt_q != 2'd2) | pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        ent_q[wr_ptr_q] <= in_dat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/harris_run_ctrl.sv
// Sequences one Harris kernel run: start pulse, count N_OUT output writes (or time out), stream memory back.
// Latency: kernel_t 1 cycle after cmd_start; first beat >= 2 cycles after READ entry; 1 beat/cycle sustained.
// Backpressure: m_ready stalls via 2-entry skid + read credit. HARRIS_RUN_CTRL_WRCHK_EN adds write-order check.
module harris_run_ctrl
  import harris_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned N_OUT   = 1024,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_order,
  output logic              kernel_t,
  input  logic              kernel_wr_en,
  input  logic [ADDR_W-1:0] kernel_wr_addr,
  output logic              out_rd_en,
  output logic [ADDR_W-1:0] out_rd_addr,
  input  logic [DATA_W-1:0] out_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int unsigned WCW = cnt_w(N_OUT);
  localparam int unsigned TCW = cnt_w(TIMEOUT);
  localparam logic [WCW-1:0] N_ALL  = WCW'(N_OUT);
  localparam logic [WCW-1:0] N_LAST = WCW'(N_OUT - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [WCW-1:0] iss_cnt_q, iss_cnt_d;
  logic [TCW-1:0] run_cnt_q, run_cnt_d;
  logic           err_to_q, err_to_d;
  logic           inflight_q;
  logic           inflight_last_q;

  logic           wr_hit;
  logic           wr_done;
  logic           timed_out;
  logic           issue;
  logic           pop;
  logic [1:0]     buf_cnt;
  logic [1:0]     occ;
  logic [DATA_W:0] sk_dat;
  logic           sk_vld;

  assign wr_hit    = (state_q == ST_RUN) && kernel_wr_en;
  assign wr_done   = wr_hit && (wr_cnt_q == N_LAST);
  assign timed_out = (run_cnt_q == T_LAST);
  assign pop       = sk_vld & m_ready;

  // Count what the buffer will hold after this cycle's pop plus the read already in flight.
  assign occ   = buf_cnt - {1'b0, pop} + {1'b0, inflight_q};
  assign issue = (state_q == ST_READ) && (iss_cnt_q != N_ALL) && (occ < 2'd2);

  assign out_rd_en   = issue;
  assign out_rd_addr = ADDR_W'(iss_cnt_q);

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign kernel_t    = (state_q == ST_START);
  assign err_timeout = err_to_q;

  assign m_valid = sk_vld;
  assign m_data  = sk_dat[DATA_W-1:0];
  assign m_last  = sk_vld & sk_dat[DATA_W];

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    run_cnt_d = run_cnt_q;
    iss_cnt_d = issue ? iss_cnt_q + WCW'(1) : iss_cnt_q;
    err_to_d  = err_to_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d   = ST_START;
          wr_cnt_d  = '0;
          run_cnt_d = '0;
          iss_cnt_d = '0;
          err_to_d  = 1'b0;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        run_cnt_d = run_cnt_q + TCW'(1);
        if (wr_hit) wr_cnt_d = wr_cnt_q + WCW'(1);
        // The final write beats a coincident timeout.
        if (wr_done) begin
          state_d = ST_READ;
        end else if (timed_out) begin
          state_d  = ST_FIN;
          err_to_d = 1'b1;
        end
      end
      ST_READ: begin
        if (pop && sk_dat[DATA_W]) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      wr_cnt_q        <= '0;
      run_cnt_q       <= '0;
      iss_cnt_q       <= '0;
      err_to_q        <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_cnt_q        <= wr_cnt_d;
      run_cnt_q       <= run_cnt_d;
      iss_cnt_q       <= iss_cnt_d;
      err_to_q        <= err_to_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (iss_cnt_q == N_LAST);
    end
  end

  harris_skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (inflight_q),
    .in_dat  ({inflight_last_q, out_rd_data}),
    .out_vld (sk_vld),
    .out_rdy (m_ready),
    .out_dat (sk_dat),
    .cnt     (buf_cnt)
  );

`ifdef HARRIS_RUN_CTRL_WRCHK_EN
  logic err_ord_q;

  // Writes must land densely in ascending order: the n-th write targets address n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ord_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && cmd_start) begin
      err_ord_q <= 1'b0;
    end else if (wr_hit && (kernel_wr_addr != ADDR_W'(wr_cnt_q))) begin
      err_ord_q <= 1'b1;
    end
  end

  assign err_order = err_ord_q;
`else
  logic unused_wr_addr;
  assign unused_wr_addr = ^kernel_wr_addr;
  assign err_order      = 1'b0;
`endif

endmodule

// File: tb/tb_harris_run_ctrl.sv
// Bench for harris_run_ctrl: a full-size instance (1024 beats) and a small one (16 beats, TIMEOUT 100).
// Kernel and output memory are behavioural; every beat is compared against the words the kernel wrote.
module tb_harris_run_ctrl;

  localparam bit WRCHK = `ifdef HARRIS_RUN_CTRL_WRCHK_EN 1'b1 `else 1'b0 `endif ;
  localparam int NA = 1024;
  localparam int NB = 16;
  localparam int TB_TO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: default geometry
  logic        a_cmd_start, a_busy, a_done, a_err_to, a_err_ord, a_kt;
  logic        a_wr_en, a_rd_en, a_m_valid, a_m_ready, a_m_last;
  logic [9:0]  a_wr_addr, a_rd_addr;
  logic [31:0] a_rd_data, a_m_data;
  logic [31:0] a_mem [1024];
  logic [31:0] exp_a [NA];

  // Instance B: short run with a small timeout
  logic        b_cmd_start, b_busy, b_done, b_err_to, b_err_ord, b_kt;
  logic        b_wr_en, b_rd_en, b_m_valid, b_m_ready, b_m_last;
  logic [9:0]  b_wr_addr, b_rd_addr;
  logic [31:0] b_rd_data, b_m_data;
  logic [31:0] b_mem [1024];
  logic [31:0] exp_b [NB];

  harris_run_ctrl u_a (
    .clk(clk), .rst(rst), .cmd_start(a_cmd_start), .busy(a_busy), .done(a_done),
    .err_timeout(a_err_to), .err_order(a_err_ord), .kernel_t(a_kt),
    .kernel_wr_en(a_wr_en), .kernel_wr_addr(a_wr_addr),
    .out_rd_en(a_rd_en), .out_rd_addr(a_rd_addr), .out_rd_data(a_rd_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last)
  );

  harris_run_ctrl #(.ADDR_W(10), .DATA_W(32), .N_OUT(NB), .TIMEOUT(TB_TO)) u_b (
    .clk(clk), .rst(rst), .cmd_start(b_cmd_start), .busy(b_busy), .done(b_done),
    .err_timeout(b_err_to), .err_order(b_err_ord), .kernel_t(b_kt),
    .kernel_wr_en(b_wr_en), .kernel_wr_addr(b_wr_addr),
    .out_rd_en(b_rd_en), .out_rd_addr(b_rd_addr), .out_rd_data(b_rd_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last)
  );

  // memref_rd models: data valid exactly one cycle after the read enable
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_cmd_start = 0; a_wr_en = 0; a_wr_addr = '0; a_m_ready = 0;
    b_cmd_start = 0; b_wr_en = 0; b_wr_addr = '0; b_m_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if ({a_busy, a_done, a_err_to, a_err_ord, a_kt, a_rd_en, a_m_valid, a_m_last} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_a_ctrl: got %b, want 00000000",
               {a_busy, a_done, a_err_to, a_err_ord, a_kt, a_rd_en, a_m_valid, a_m_last});
    end
    n_assert++;
    if (a_m_data !== 32'h0 || a_rd_addr !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_a_data: m_data=%h rd_addr=%h, want 0 0", a_m_data, a_rd_addr);
    end
    n_assert++;
    if ({b_busy, b_done, b_err_to, b_err_ord, b_kt, b_rd_en, b_m_valid, b_m_last} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_b_ctrl: got %b, want 00000000",
               {b_busy, b_done, b_err_to, b_err_ord, b_kt, b_rd_en, b_m_valid, b_m_last});
    end
    rst = 1'b0;
    tick;
  endtask

  // One full-size run. mode 0: m_ready held high, 1: toggling, 2: random stalls.
  task automatic run_a(input int mode);
    int cyc, w, wr_end, nb, first_v, last_beat, done_cyc;
    logic stalled;
    logic [31:0] held;
    for (int i = 0; i < NA; i++) exp_a[i] = $urandom;
    a_cmd_start = 1'b1;
    tick;
    a_cmd_start = 1'b0;
    n_assert++;
    if (a_kt !== 1'b1 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_pulse m%0d: kernel_t=%b busy=%b, want 1 1", mode, a_kt, a_busy);
    end
    tick;
    n_assert++;
    if (a_kt !== 1'b0 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_single m%0d: kernel_t=%b busy=%b, want 0 1", mode, a_kt, a_busy);
    end
    cyc = 2; w = 0; wr_end = 0;
    while (w < NA && cyc < 8000) begin
      a_cmd_start = ($urandom % 8 == 0);
      if ($urandom % 4 != 0) begin
        a_wr_en = 1'b1; a_wr_addr = w[9:0]; a_mem[w] = exp_a[w];
        wr_end = cyc; w++;
      end else begin
        a_wr_en = 1'b0;
      end
      n_assert++;
      if (a_busy !== 1'b1 || a_done !== 1'b0 || a_m_valid !== 1'b0 || a_kt !== 1'b0) begin
        n_fail++;
        $display("FAIL run_phase m%0d cyc%0d: busy=%b done=%b m_valid=%b kernel_t=%b, want 1 0 0 0",
                 mode, cyc, a_busy, a_done, a_m_valid, a_kt);
      end
      tick; cyc++;
    end
    a_wr_en = 1'b0;
    nb = 0; first_v = -1; last_beat = -1; done_cyc = -1; stalled = 1'b0; held = '0;
    while (cyc < 20000) begin
      if (a_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      case (mode)
        0:       a_m_ready = 1'b1;
        1:       a_m_ready = cyc[0];
        default: a_m_ready = ($urandom % 10 < 7);
      endcase
      a_cmd_start = ($urandom % 8 == 0);
      a_wr_en     = ($urandom % 5 == 0);
      a_wr_addr   = 10'($urandom);
      if (stalled) begin
        n_assert++;
        if (a_m_valid !== 1'b1 || a_m_data !== held) begin
          n_fail++;
          $display("FAIL stall_hold m%0d cyc%0d: valid=%b data=%h, want 1 %h", mode, cyc, a_m_valid, a_m_data, held);
        end
      end
      if (a_m_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        if (a_m_ready) begin
          n_assert++;
          if (nb >= NA) begin
            n_fail++;
            $display("FAIL extra_beat m%0d: beat %0d, want at most %0d", mode, nb, NA);
          end else if (a_m_data !== exp_a[nb] || a_m_last !== (nb == NA - 1)) begin
            n_fail++;
            $display("FAIL beat m%0d #%0d: data=%h last=%b, want %h %b", mode, nb, a_m_data, a_m_last, exp_a[nb], (nb == NA - 1));
          end
          nb++; last_beat = cyc; stalled = 1'b0;
        end else begin
          stalled = 1'b1; held = a_m_data;
        end
      end
      tick; cyc++;
    end
    a_cmd_start = 1'b0; a_wr_en = 1'b0;
    n_assert++;
    if (done_cyc < 0 || nb != NA) begin
      n_fail++;
      $display("FAIL run_complete m%0d: done_cycle=%0d beats=%0d, want done seen and %0d beats", mode, done_cyc, nb, NA);
    end
    n_assert++;
    if (done_cyc != last_beat + 1) begin
      n_fail++;
      $display("FAIL done_timing m%0d: done at %0d, want %0d", mode, done_cyc, last_beat + 1);
    end
    n_assert++;
    if (first_v < wr_end + 3) begin
      n_fail++;
      $display("FAIL first_valid m%0d: at %0d, want >= %0d", mode, first_v, wr_end + 3);
    end
    if (mode == 0) begin
      n_assert++;
      if (last_beat - first_v != NA - 1) begin
        n_fail++;
        $display("FAIL throughput: %0d cycles for %0d beats, want %0d", last_beat - first_v + 1, NA, NA);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      n_assert++;
      if (a_busy !== 1'b0 || a_done !== 1'b0 || a_kt !== 1'b0) begin
        n_fail++;
        $display("FAIL post_run m%0d +%0d: busy=%b done=%b kernel_t=%b, want 0 0 0", mode, k, a_busy, a_done, a_kt);
      end
    end
  endtask

  task automatic test_full_throughput;
    run_a(0);
  endtask

  task automatic test_stalls;
    run_a(1);
    run_a(2);
  endtask

  // Drains instance B with random m_ready; returns beats and whether done was seen.
  task automatic drain_b(input bit chk_data, output int nb, output bit seen);
    nb = 0; seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (b_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      b_m_ready = ($urandom % 3 != 0);
      if (b_m_valid === 1'b1 && b_m_ready) begin
        if (chk_data) begin
          n_assert++;
          if (nb >= NB || b_m_data !== exp_b[nb] || b_m_last !== (nb == NB - 1)) begin
            n_fail++;
            $display("FAIL b_beat #%0d: data=%h last=%b, want %h %b", nb, b_m_data, b_m_last,
                     (nb < NB) ? exp_b[nb] : 32'h0, (nb == NB - 1));
          end
        end
        nb++;
      end
      tick;
    end
  endtask

  task automatic test_timeout;
    int k, nb;
    bit seen;
    b_cmd_start = 1'b1; tick; b_cmd_start = 1'b0; tick;
    k = 0;
    for (int r = 0; r <= TB_TO + 4; r++) begin
      if (k < 10 && r == k * 9 + 2) begin
        b_wr_en = 1'b1; b_wr_addr = k[9:0]; k++;
      end else begin
        b_wr_en = 1'b0;
      end
      n_assert++;
      if (b_done !== (r == TB_TO) || b_err_to !== (r >= TB_TO) || b_busy !== (r <= TB_TO) ||
          b_m_valid !== 1'b0 || b_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout r%0d: done=%b err_to=%b busy=%b valid=%b rd_en=%b, want %b %b %b 0 0",
                 r, b_done, b_err_to, b_busy, b_m_valid, b_rd_en, (r == TB_TO), (r >= TB_TO), (r <= TB_TO));
      end
      tick;
    end
    b_wr_en = 1'b0;
    // New run clears the sticky error; its final write lands on the last RUN cycle.
    for (int i = 0; i < NB; i++) exp_b[i] = $urandom;
    b_cmd_start = 1'b1; tick; b_cmd_start = 1'b0;
    n_assert++;
    if (b_err_to !== 1'b0 || b_kt !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_clear: err_timeout=%b kernel_t=%b, want 0 1", b_err_to, b_kt);
    end
    tick;
    for (int r = 0; r < TB_TO; r++) begin
      if (r >= TB_TO - NB) begin
        b_wr_en = 1'b1; b_wr_addr = 10'(r - (TB_TO - NB)); b_mem[r - (TB_TO - NB)] = exp_b[r - (TB_TO - NB)];
      end else begin
        b_wr_en = 1'b0;
      end
      tick;
    end
    b_wr_en = 1'b0;
    n_assert++;
    if (b_done !== 1'b0 || b_err_to !== 1'b0 || b_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL complete_wins: done=%b err_to=%b busy=%b, want 0 0 1", b_done, b_err_to, b_busy);
    end
    drain_b(1'b1, nb, seen);
    n_assert++;
    if (!seen || nb != NB || b_err_to !== 1'b0) begin
      n_fail++;
      $display("FAIL complete_wins_drain: done=%b beats=%0d err_to=%b, want 1 %0d 0", seen, nb, b_err_to, NB);
    end
    tick;
  endtask

  task automatic test_write_order;
    int nb;
    bit seen;
    b_cmd_start = 1'b1; tick; b_cmd_start = 1'b0; tick;
    for (int k = 0; k < NB; k++) begin
      b_wr_en = 1'b1;
      b_wr_addr = (k == 6) ? 10'd5 : 10'(k);
      b_mem[b_wr_addr] = $urandom;
      if (k == 6 || k == 7) begin
        n_assert++;
        if (b_err_ord !== ((k == 7) ? WRCHK : 1'b0)) begin
          n_fail++;
          $display("FAIL err_order k%0d: got %b, want %b", k, b_err_ord, (k == 7) ? WRCHK : 1'b0);
        end
      end
      tick;
    end
    b_wr_en = 1'b0;
    drain_b(1'b0, nb, seen);
    n_assert++;
    if (!seen || nb != NB || b_err_ord !== WRCHK) begin
      n_fail++;
      $display("FAIL order_run_end: done=%b beats=%0d err_order=%b, want 1 %0d %b", seen, nb, b_err_ord, NB, WRCHK);
    end
    tick;
  endtask

  task automatic test_async_reset;
    b_cmd_start = 1'b1; tick; b_cmd_start = 1'b0;
    n_assert++;
    if (b_err_ord !== 1'b0 || b_err_to !== 1'b0) begin
      n_fail++;
      $display("FAIL errs_cleared: err_order=%b err_timeout=%b, want 0 0", b_err_ord, b_err_to);
    end
    tick;
    b_m_ready = 1'b0;
    for (int k = 0; k < NB; k++) begin
      b_wr_en = 1'b1; b_wr_addr = 10'(k); tick;
    end
    b_wr_en = 1'b0;
    repeat (4) tick;
    n_assert++;
    if (b_m_valid !== 1'b1 || b_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: m_valid=%b busy=%b, want 1 1", b_m_valid, b_busy);
    end
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if ({b_busy, b_done, b_err_to, b_err_ord, b_kt, b_rd_en, b_m_valid, b_m_last} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got %b, want 00000000",
               {b_busy, b_done, b_err_to, b_err_ord, b_kt, b_rd_en, b_m_valid, b_m_last});
    end
    tick;
    rst = 1'b0;
    b_m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      n_assert++;
      if (b_busy !== 1'b0 || b_m_valid !== 1'b0 || b_done !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset +%0d: busy=%b m_valid=%b done=%b, want 0 0 0", k, b_busy, b_m_valid, b_done);
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_full_throughput;
    test_stalls;
    test_timeout;
    test_write_order;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
